mmp_iddmm_col_acc128: RTL and testbench

//  Product-scanning (Comba) column accumulator. Sits directly downstream of the 128x128 IDDMM

---
 rtl/mmp_iddmm_pkg.sv | 22 ++
 rtl/mmp_iddmm_col_acc128.sv | 126 ++++++++++++
 tb/tb_mmp_iddmm_col_acc128.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmp_iddmm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmp_iddmm_pkg
// Description : Shared constants and state encoding for the IDDMM datapath
//               (word/product widths, default operand length, column
//               accumulator FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package mmp_iddmm_pkg;

    localparam int WORD_W      = 128;   // result word width
    localparam int PROD_W      = 256;   // multiplier product width
    localparam int N_WORDS_DEF = 32;    // default operand length in words

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FLUSH = 2'd2
    } acc_state_t;

endpackage : mmp_iddmm_pkg
`default_nettype wire

// File: rtl/mmp_iddmm_col_acc128.sv
`default_nettype none
// ============================================================================
// Module      : mmp_iddmm_col_acc128
// Description : Product-scanning (Comba) column accumulator. Sums all 256-bit
//               products of one column, emits the low 128-bit word when the
//               column closes, carries the upper bits into the next column and
//               flushes the final top word. Emits 2*N_WORDS words in total.
// Ports       : clk, rst_n (async, active low)
//               start            - 1-cycle pulse, clears state and enters ACC
//               prod_valid/prod_in - product stream (no backpressure)
//               col_end          - current cycle closes the current column
//               out_valid/out_word/out_idx - result word stream
//               busy             - high while accumulating or flushing
//               done             - pulse with the last (top) word
//               err              - sticky protocol/overflow error
// Latency     : out_valid is registered one cycle after the col_end cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mmp_iddmm_col_acc128
    import mmp_iddmm_pkg::*;
#(
    parameter int N_WORDS = N_WORDS_DEF,
    parameter int ACC_W   = PROD_W + $clog2(N_WORDS) + 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          prod_valid,
    input  logic [PROD_W-1:0]             prod_in,
    input  logic                          col_end,
    output logic                          out_valid,
    output logic [WORD_W-1:0]             out_word,
    output logic [$clog2(2*N_WORDS)-1:0]  out_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int                 c_IDX_W    = $clog2(2*N_WORDS);
    // Last column closed inside ACC; the top word comes from FLUSH.
    localparam logic [c_IDX_W-1:0] c_LAST_COL = c_IDX_W'(2*N_WORDS - 2);
    localparam logic [c_IDX_W-1:0] c_TOP_IDX  = c_IDX_W'(2*N_WORDS - 1);

    acc_state_t           r_state;
    logic [ACC_W-1:0]     r_acc;
    logic [c_IDX_W-1:0]   r_col_cnt;

    logic [PROD_W-1:0]    w_addend;
    logic [ACC_W:0]       w_sum;       // one extra bit to catch wrap-around
    logic [ACC_W-1:0]     w_sum_shr;

    assign w_addend  = prod_valid ? prod_in : '0;
    assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(w_addend);
    assign w_sum_shr = w_sum[ACC_W-1:0] >> WORD_W;

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_col_cnt <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_idx   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;

            if (start) begin
                // Start wins over any coincident product or column end.
                r_state   <= ST_ACC;
                r_acc     <= '0;
                r_col_cnt <= '0;
                err       <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (prod_valid || col_end) begin
                            err <= 1'b1;
                        end
                    end

                    ST_ACC: begin
                        if (w_sum[ACC_W]) begin
                            err <= 1'b1;
                        end
                        if (col_end) begin
                            out_word  <= w_sum[WORD_W-1:0];
                            out_idx   <= r_col_cnt;
                            out_valid <= 1'b1;
                            r_acc     <= w_sum_shr;
                            r_col_cnt <= r_col_cnt + c_IDX_W'(1);
                            if (r_col_cnt == c_LAST_COL) begin
                                r_state <= ST_FLUSH;
                            end
                        end else begin
                            r_acc <= w_sum[ACC_W-1:0];
                        end
                    end

                    ST_FLUSH: begin
                        out_word  <= r_acc[WORD_W-1:0];
                        out_idx   <= c_TOP_IDX;
                        out_valid <= 1'b1;
                        done      <= 1'b1;
                        // Anything above the top word means the result did
                        // not fit into 2*N_WORDS words.
                        if (|r_acc[ACC_W-1:WORD_W]) begin
                            err <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule : mmp_iddmm_col_acc128
`default_nettype wire

// File: tb/tb_mmp_iddmm_col_acc128.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmp_iddmm_col_acc128
// Description : Self-checking bench for the column accumulator. Two instances
//               (N_WORDS=1 and N_WORDS=2) share clock and reset. Expected
//               words come from the full integer sum of column-weighted
//               products, split into 128-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmp_iddmm_col_acc128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // N_WORDS = 1 instance
    logic         s1, pv1, ce1;
    logic [255:0] pi1;
    logic         ov1, b1, dn1, e1;
    logic [127:0] ow1;
    logic [0:0]   oi1;

    // N_WORDS = 2 instance
    logic         s2, pv2, ce2;
    logic [255:0] pi2;
    logic         ov2, b2, dn2, e2;
    logic [127:0] ow2;
    logic [1:0]   oi2;

    mmp_iddmm_col_acc128 #(.N_WORDS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .prod_valid(pv1), .prod_in(pi1),
        .col_end(ce1), .out_valid(ov1), .out_word(ow1), .out_idx(oi1),
        .busy(b1), .done(dn1), .err(e1)
    );

    mmp_iddmm_col_acc128 #(.N_WORDS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(s2), .prod_valid(pv2), .prod_in(pi2),
        .col_end(ce2), .out_valid(ov2), .out_word(ow2), .out_idx(oi2),
        .busy(b2), .done(dn2), .err(e2)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] c_ONES = {256{1'b1}};

    // Output capture
    int           m1_cnt, m2_cnt, m2_done_seen;
    logic [127:0] m1_w [0:7];
    int           m1_i [0:7];
    logic         m1_d [0:7];
    logic [127:0] m2_w [0:7];
    int           m2_i [0:7];
    logic         m2_d [0:7];

    always @(negedge clk) begin
        if (ov1) begin
            if (m1_cnt < 8) begin
                m1_w[m1_cnt] = ow1;
                m1_i[m1_cnt] = int'(oi1);
                m1_d[m1_cnt] = dn1;
            end
            m1_cnt++;
        end
        if (ov2) begin
            if (m2_cnt < 8) begin
                m2_w[m2_cnt] = ow2;
                m2_i[m2_cnt] = int'(oi2);
                m2_d[m2_cnt] = dn2;
            end
            m2_cnt++;
        end
        if (dn2) m2_done_seen++;
    end

    // Column contents for the N_WORDS=2 instance: 3 columns, up to 4 products
    int           cn [0:2];
    logic [255:0] cp [0:2][0:3];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        if ($urandom_range(0, 3) == 0) r = c_ONES;
        return r;
    endfunction

    // N_WORDS=1: one column holding a single product p.
    task automatic run1(input string tag, input logic [255:0] p);
        m1_cnt = 0;
        s1 = 1'b1; tick(); s1 = 1'b0;
        pv1 = 1'b1; pi1 = p; ce1 = 1'b1; tick();
        pv1 = 1'b0; pi1 = '0; ce1 = 1'b0;
        tick(); tick(); tick();
        check({tag, "_cnt"}, 256'(m1_cnt), 256'd2);
        check({tag, "_w0"}, 256'(m1_w[0]), 256'(p[127:0]));
        check({tag, "_w1"}, 256'(m1_w[1]), 256'(p[255:128]));
        check({tag, "_i0"}, 256'(m1_i[0]), 256'd0);
        check({tag, "_i1"}, 256'(m1_i[1]), 256'd1);
        check({tag, "_d0"}, 256'(m1_d[0]), 256'd0);
        check({tag, "_d1"}, 256'(m1_d[1]), 256'd1);
        check({tag, "_err"}, 256'(e1), 256'd0);
        check({tag, "_busy"}, 256'(b1), 256'd0);
    endtask

    // Drives start then the three columns held in cn/cp (no waiting after).
    task automatic drive2();
        m2_cnt = 0;
        m2_done_seen = 0;
        s2 = 1'b1; tick(); s2 = 1'b0;
        pv2 = 1'b0; ce2 = 1'b0; pi2 = '0;
        for (int c = 0; c < 3; c++) begin
            if (cn[c] == 0) begin
                ce2 = 1'b1; tick(); ce2 = 1'b0;
            end else begin
                for (int k = 0; k < cn[c]; k++) begin
                    pv2 = 1'b1;
                    pi2 = cp[c][k];
                    ce2 = (k == cn[c] - 1);
                    tick();
                end
            end
            pv2 = 1'b0; ce2 = 1'b0; pi2 = '0;
        end
    endtask

    // Full run on the N_WORDS=2 instance, checked against the integer sum
    // total = sum over columns c of (column sum) * 2^(128*c).
    task automatic run2(input string tag);
        logic [1023:0] tot;
        drive2();
        tick(); tick(); tick();
        tot = '0;
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < cn[c]; k++)
                tot = tot + ({768'd0, cp[c][k]} << (128 * c));
        check({tag, "_cnt"}, 256'(m2_cnt), 256'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_w%0d", tag, i), 256'(m2_w[i]), 256'(tot[128*i +: 128]));
            check($sformatf("%s_i%0d", tag, i), 256'(m2_i[i]), 256'(i));
            check($sformatf("%s_d%0d", tag, i), 256'(m2_d[i]), 256'(i == 3));
        end
        check({tag, "_err"}, 256'(e2), 256'(|tot[1023:512]));
        check({tag, "_ndone"}, 256'(m2_done_seen), 256'd1);
        check({tag, "_busy"}, 256'(b2), 256'd0);
    endtask

    task automatic setup_t2();
        cn[0] = 1; cn[1] = 2; cn[2] = 1;
        cp[0][0] = c_ONES;
        cp[1][0] = c_ONES;
        cp[1][1] = c_ONES;
        cp[2][0] = 256'd1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        s1 = 0; pv1 = 0; ce1 = 0; pi1 = '0;
        s2 = 0; pv2 = 0; ce2 = 0; pi2 = '0;
        m1_cnt = 0; m2_cnt = 0; m2_done_seen = 0;
        tick(); tick();

        // Reset state
        check("rst_ov2", 256'(ov2), 256'd0);
        check("rst_ow2", 256'(ow2), 256'd0);
        check("rst_oi2", 256'(oi2), 256'd0);
        check("rst_busy2", 256'(b2), 256'd0);
        check("rst_done2", 256'(dn2), 256'd0);
        check("rst_err2", 256'(e2), 256'd0);
        check("rst_err1", 256'(e1), 256'd0);
        rst_n = 1'b1;
        tick();

        // T1: single column of all-ones
        run1("t1", c_ONES);

        // T2: carry chain, also against the literal word values
        setup_t2();
        run2("t2");
        check("t2_lit0", 256'(m2_w[0]), 256'({128{1'b1}}));
        check("t2_lit1", 256'(m2_w[1]), 256'({128{1'b1}} - 128'd2));
        check("t2_lit2", 256'(m2_w[2]), 256'd1);
        check("t2_lit3", 256'(m2_w[3]), 256'd2);

        // T3: empty first column
        cn[0] = 0; cn[1] = 1; cn[2] = 1;
        cp[1][0] = 256'd5;
        cp[2][0] = 256'd0;
        run2("t3");
        check("t3_lit1", 256'(m2_w[1]), 256'd5);

        // Overflow of the top word sets err
        cn[0] = 0; cn[1] = 0; cn[2] = 2;
        cp[2][0] = c_ONES;
        cp[2][1] = c_ONES;
        run2("ovf");
        check("ovf_err_lit", 256'(e2), 256'd1);

        // T4: product in IDLE is a protocol error, no output
        m1_cnt = 0;
        pv1 = 1'b1; pi1 = 256'd7; tick();
        pv1 = 1'b0; pi1 = '0;
        tick(); tick();
        check("t4_noout", 256'(m1_cnt), 256'd0);
        check("t4_err", 256'(e1), 256'd1);
        run1("t4_t1", c_ONES);

        // T5: abort mid column 1, start coincides with a product + col_end
        s2 = 1'b1; tick(); s2 = 1'b0;
        pv2 = 1'b1; pi2 = c_ONES; ce2 = 1'b1; tick();
        ce2 = 1'b0; pi2 = rnd256(); tick();
        pi2 = c_ONES; ce2 = 1'b1;
        setup_t2();
        run2("t5");

        // T6: reset during the FLUSH cycle
        setup_t2();
        drive2();
        check("t6_busy_pre", 256'(b2), 256'd1);
        rst_n = 1'b0;
        #1;
        check("t6_ov", 256'(ov2), 256'd0);
        check("t6_ow", 256'(ow2), 256'd0);
        check("t6_oi", 256'(oi2), 256'd0);
        check("t6_done", 256'(dn2), 256'd0);
        check("t6_busy", 256'(b2), 256'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("t6_ndone", 256'(m2_done_seen), 256'd0);
        check("t6_idle", 256'(b2), 256'd0);

        // Randomized columns on N_WORDS=2
        for (int it = 0; it < 8; it++) begin
            for (int c = 0; c < 3; c++) begin
                cn[c] = int'($urandom_range(0, 3));
                for (int k = 0; k < 4; k++) cp[c][k] = rnd256();
            end
            run2($sformatf("rnd%0d", it));
        end

        // Randomized single products on N_WORDS=1
        for (int it = 0; it < 4; it++) begin
            run1($sformatf("r1_%0d", it), rnd256());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mmp_iddmm_col_acc128
`default_nettype wire
